muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (even, >=8).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port valid_in  input  1  operation request.
REQ-005 SHALL have port ready  output  1  high when a request can be accepted.
REQ-006 SHALL have port op  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 SHALL have port A  input  WIDTH  operand rs1.
REQ-008 SHALL have port B  input  WIDTH  operand rs2.
REQ-009 SHALL have port flush  input  1  abort in-flight operation.
REQ-010 SHALL have port valid_out  output  1  one-cycle result-valid pulse.
REQ-011 SHALL have port result  output  WIDTH  result of the last completed operation.
REQ-012 SHALL have port busy  output  1  high in CALC or DONE.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, DONE.
REQ-014 ready SHALL equal (state==IDLE); accept = valid_in & ready & ~flush.
REQ-015 On accept, SHALL latch op, operand magnitudes and result-sign flags, clear the iteration counter, and go to CALC.
REQ-016 SHALL take the special-case path instead (accept -> DONE directly) for divide ops with B==0, and for DIV/REM with A==most-negative, B==all-ones.
REQ-017 CALC SHALL process one bit per cycle: shift-add for multiply (2*WIDTH-bit product), restoring shift-subtract for divide; exactly WIDTH cycles, then DONE.
REQ-018 Normal latency: valid_out SHALL assert WIDTH+1 cycles after the accept edge; special-case latency SHALL be 1 cycle.
REQ-019 In DONE, valid_out SHALL be 1 for exactly one cycle, result SHALL update that cycle, and state SHALL return to IDLE next cycle.
REQ-020 result SHALL hold its value until the next DONE; it SHALL NOT change on accept or flush.
REQ-021 MUL SHALL return product[WIDTH-1:0]; MULH/MULHSU/MULHU SHALL return product[2*WIDTH-1:WIDTH] with signed x signed, signed x unsigned and unsigned x unsigned operands respectively.
REQ-022 Signed ops SHALL iterate on magnitudes and negate at completion when the sign flag is set; quotient sign = sign(A) xor sign(B); remainder sign = sign(A).
REQ-023 Divide by zero: DIV/DIVU SHALL return all-ones; REM/REMU SHALL return A.
REQ-024 Signed overflow (most-negative / -1): DIV SHALL return A; REM SHALL return 0.
REQ-025 flush in CALC or DONE SHALL force IDLE next cycle with no valid_out and result unchanged; flush in IDLE SHALL block accept.
REQ-026 Inputs A, B, op SHALL be ignored except in the accept cycle.

Reset
REQ-027 rst high SHALL immediately force state IDLE, result 0, valid_out 0, busy 0, counter 0, whatever the current state.
REQ-028 ready SHALL be 1 in the first cycle after rst deasserts.

Verification (WIDTH=32)
REQ-029 MUL A=7, B=0xFFFFFFFD -> valid_out 33 cycles after accept, result 0xFFFFFFEB; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULH 0x80000000*0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF.
REQ-030 DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-031 DIVU 5/0 -> 0xFFFFFFFF one cycle after accept; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0.
REQ-032 Accept MUL 3*4, flush 10 cycles later -> no valid_out, ready high next cycle, result keeps its prior value; a following MUL 3*4 -> 12.
REQ-033 Assert rst 20 cycles into a DIV -> outputs 0 immediately; after release, DIVU 9/3 -> 3 with normal latency.
REQ-034 Hold valid_in high continuously with changing operands -> exactly one accept per IDLE cycle, with back-to-back results matching the operands latched at each accept.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative integer multiply/divide unit (RISC-V M-extension semantics).
// One bit is processed per clock: shift-add for multiplies, restoring
// shift-subtract for divides. Signed operations run on magnitudes and are
// negated on completion. Divide-by-zero and signed overflow bypass the
// iteration and complete one cycle after accept.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   valid_in  operation request
//   ready     high when a request can be accepted (state IDLE)
//   op        0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//   A, B      operands rs1 / rs2
//   flush     abort the in-flight operation; blocks accept while in IDLE
//   valid_out one-cycle result-valid pulse
//   result    result of the last completed operation
//   busy      high in CALC or DONE
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  output logic             ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             flush,
  output logic             valid_out,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2:0]         op_q;
  logic               neg_q;
  logic               spec_q;
  logic               valid_out_q;
  logic [WIDTH-1:0]   result_q;

  // Datapath: for multiply, high half accumulates and low half holds the
  // multiplier shifting out; for divide, high half is the partial remainder
  // and low half holds the dividend shifting out / quotient shifting in.
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  // Accept-cycle decode
  logic             accept;
  logic             is_div;
  logic             signed_a, signed_b;
  logic             neg_a, neg_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             div_zero, div_ovf, special;
  logic [WIDTH-1:0] spec_val;
  logic             neg_res;

  assign ready    = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign accept   = valid_in & ready & ~flush;
  assign is_div   = op[2];
  assign signed_a = (op != OP_MULHU) && (op != OP_DIVU) && (op != OP_REMU);
  assign signed_b = (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  assign neg_a    = signed_a & A[WIDTH-1];
  assign neg_b    = signed_b & B[WIDTH-1];
  assign mag_a    = cond_neg(A, neg_a);
  assign mag_b    = cond_neg(B, neg_b);
  assign div_zero = is_div && (B == '0);
  assign div_ovf  = ((op == OP_DIV) || (op == OP_REM)) &&
                    (A == {1'b1, {(WIDTH-1){1'b0}}}) && (B == '1);
  assign special  = div_zero | div_ovf;
  // REM/REMU take A on divide-by-zero and 0 on overflow; DIV/DIVU take all-ones / A.
  assign spec_val = op[1] ? (div_zero ? A : '0) : (div_zero ? '1 : A);
  // Remainder follows the dividend sign; everything else is sign(A) xor sign(B).
  assign neg_res  = op[1] & op[2] ? neg_a : (neg_a ^ neg_b);

  // One iteration step
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh, div_diff;
  logic [2*WIDTH-1:0] mul_step, div_step;

  assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_step = {mul_sum, prod_q[WIDTH-1:1]};
  assign div_sh   = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, opnd_q};
  // A clear top bit means the trial subtraction did not go negative.
  assign div_step = div_diff[WIDTH] ? {div_sh[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};

  always_comb begin
    prod_d = prod_q;
    opnd_d = opnd_q;
    if (accept) begin
      if (special) begin
        prod_d = {{WIDTH{1'b0}}, spec_val};
      end else if (is_div) begin
        opnd_d = mag_b;
        prod_d = {{WIDTH{1'b0}}, mag_a};
      end else begin
        opnd_d = mag_a;
        prod_d = {{WIDTH{1'b0}}, mag_b};
      end
    end else if (state_q == CALC) begin
      prod_d = op_q[2] ? div_step : mul_step;
    end
  end

  always_ff @(posedge clk) begin
    prod_q <= prod_d;
    opnd_q <= opnd_d;
  end

  // Completion formatting
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   final_res;

  assign prod_fix = cond_neg2(prod_q, neg_q);

  always_comb begin
    final_res = '0;
    if (spec_q) begin
      final_res = prod_q[WIDTH-1:0];
    end else if (!op_q[2]) begin
      final_res = (op_q == OP_MUL) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
    end else if (op_q[1]) begin
      final_res = cond_neg(prod_q[2*WIDTH-1:WIDTH], neg_q);
    end else begin
      final_res = cond_neg(prod_q[WIDTH-1:0], neg_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      neg_q       <= 1'b0;
      spec_q      <= 1'b0;
      valid_out_q <= 1'b0;
      result_q    <= '0;
    end else begin
      valid_out_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q    <= op;
            neg_q   <= neg_res;
            spec_q  <= special;
            cnt_q   <= '0;
            state_q <= special ? DONE : CALC;
          end
        end
        CALC: begin
          if (flush) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH-1)) state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
          if (!flush) begin
            valid_out_q <= 1'b1;
            result_q    <= final_res;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign valid_out = valid_out_q;
  assign result    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  localparam int W = 32;
  localparam int NLAT = W + 1;

  logic          clk;
  logic          rst;
  logic          valid_in;
  logic          ready;
  logic [2:0]    op;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic          flush;
  logic          valid_out;
  logic [W-1:0]  result;
  logic          busy;

  int vectors;
  int miscompares;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .ready     (ready),
    .op        (op),
    .A         (A),
    .B         (B),
    .flush     (flush),
    .valid_out (valid_out),
    .result    (result),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    int           lat;
  } vec_t;

  // Reference model: architectural result straight from the arithmetic rules.
  function automatic logic [W-1:0] model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0]        p;
    logic signed [2*W-1:0] sp;
    logic signed [W-1:0]   sa, sb, sq;
    logic                  ovf;
    sa  = $signed(a);
    sb  = $signed(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[W-1:0]; end
      3'd1: begin sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return sp[2*W-1:W]; end
      3'd2: begin sp = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); return sp[2*W-1:W]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[2*W-1:W]; end
      3'd4: begin
        if (b == '0) return '1;
        if (ovf) return a;
        sq = sa / sb; return sq;
      end
      3'd5: begin if (b == '0) return '1; return a / b; end
      3'd6: begin
        if (b == '0) return a;
        if (ovf) return '0;
        sq = sa % sb; return sq;
      end
      default: begin if (b == '0) return a; return a % b; end
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    if (o[2] && b == '0) return 1;
    if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return NLAT;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] res, output int lat);
    @(negedge clk);
    op = o; A = a; B = b; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    // Operands are don't-care after the accept edge.
    op = 3'($urandom); A = $urandom; B = $urandom;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk); lat++; #1;
      if (valid_out) break;
    end
    res = result;
  endtask

  vec_t         tbl[12];
  logic [W-1:0] res, prev;
  int           lat;
  logic [2:0]   op_h[0:255];
  logic [W-1:0] a_h[0:255];
  logic [W-1:0] b_h[0:255];

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1; valid_in = 1'b0; flush = 1'b0; op = '0; A = '0; B = '0;

    tbl[0]  = '{3'd0, 32'h7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
    tbl[1]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    tbl[2]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
    tbl[3]  = '{3'd2, 32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFF, 33};
    tbl[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, 33};
    tbl[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 33};
    tbl[6]  = '{3'd5, 32'd100,       32'd7,         32'd14,        33};
    tbl[7]  = '{3'd7, 32'd100,       32'd7,         32'd2,         33};
    tbl[8]  = '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
    tbl[9]  = '{3'd6, 32'd5,         32'd0,         32'd5,         1};
    tbl[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    tbl[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", result, '0);
    chk("rst_valid_out", {31'b0, valid_out}, '0);
    chk("rst_busy", {31'b0, busy}, '0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", {31'b0, ready}, 32'd1);

    // Directed table
    for (int i = 0; i < 12; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, res, lat);
      chk($sformatf("tbl%0d_result", i), res, tbl[i].exp);
      chk($sformatf("tbl%0d_latency", i), 32'(lat), 32'(tbl[i].lat));
    end

    // Flush in IDLE blocks accept
    @(negedge clk); op = 3'd0; A = 32'd3; B = 32'd4; valid_in = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    chk("flush_idle_busy", {31'b0, busy}, '0);
    valid_in = 1'b0; flush = 1'b0;

    // Flush 10 cycles into a MUL
    prev = result;
    @(negedge clk); op = 3'd0; A = 32'd3; B = 32'd4; valid_in = 1'b1;
    @(posedge clk); #1; valid_in = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    chk("flush_calc_ready", {31'b0, ready}, 32'd1);
    chk("flush_calc_valid_out", {31'b0, valid_out}, '0);
    begin
      logic seen;
      seen = 1'b0;
      repeat (40) begin @(posedge clk); #1; if (valid_out) seen = 1'b1; end
      chk("flush_calc_no_pulse", {31'b0, seen}, '0);
    end
    chk("flush_calc_result_held", result, prev);
    run_op(3'd0, 32'd3, 32'd4, res, lat);
    chk("mul_after_flush", res, 32'd12);
    chk("mul_after_flush_lat", 32'(lat), 32'(NLAT));

    // Flush in DONE (special-case op)
    run_op(3'd5, 32'd100, 32'd7, res, lat);
    @(negedge clk); op = 3'd5; A = 32'd5; B = 32'd0; valid_in = 1'b1;
    @(posedge clk); #1; valid_in = 1'b0;
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    chk("flush_done_valid_out", {31'b0, valid_out}, '0);
    chk("flush_done_result", result, 32'd14);
    chk("flush_done_ready", {31'b0, ready}, 32'd1);

    // Asynchronous reset 20 cycles into a DIV
    @(negedge clk); op = 3'd4; A = 32'd1000; B = 32'd3; valid_in = 1'b1;
    @(posedge clk); #1; valid_in = 1'b0;
    repeat (20) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_result", result, '0);
    chk("async_rst_busy", {31'b0, busy}, '0);
    chk("async_rst_valid_out", {31'b0, valid_out}, '0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("async_rst_ready", {31'b0, ready}, 32'd1);
    run_op(3'd5, 32'd9, 32'd3, res, lat);
    chk("divu_after_rst", res, 32'd3);
    chk("divu_after_rst_lat", 32'(lat), 32'(NLAT));

    // Randomized against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [2:0]   o;
      logic [W-1:0] a, b;
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op(o, a, b, res, lat);
      chk($sformatf("rand%0d_op%0d_result", i, o), res, model(o, a, b));
      chk($sformatf("rand%0d_op%0d_latency", i, o), 32'(lat), 32'(model_lat(o, a, b)));
    end

    // valid_in held high with operands changing every cycle
    for (int cyc = 0; cyc < 4 * (W + 2); cyc++) begin
      @(negedge clk);
      op_h[cyc] = 3'($urandom_range(0, 7));
      a_h[cyc]  = $urandom;
      b_h[cyc]  = $urandom | 32'd1;
      if (a_h[cyc] == 32'h8000_0000) a_h[cyc] = 32'd1;
      op = op_h[cyc]; A = a_h[cyc]; B = b_h[cyc]; valid_in = 1'b1;
      @(posedge clk); #1;
      begin
        logic exp_v;
        int   acc;
        exp_v = (cyc >= NLAT) && (((cyc - NLAT) % (W + 2)) == 0);
        chk($sformatf("b2b_cyc%0d_valid_out", cyc), {31'b0, valid_out}, {31'b0, exp_v});
        if (exp_v) begin
          acc = cyc - NLAT;
          chk($sformatf("b2b_cyc%0d_result", cyc), result, model(op_h[acc], a_h[acc], b_h[acc]));
        end
      end
    end
    @(negedge clk); valid_in = 1'b0;
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
